// File: rtl/run_checker_pkg.sv
// Shared types for the run monitor: FSM state encoding and fail codes.
package run_checker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RSTCHK,
    RUN,
    HALTCHK,
    SWEEP_RD,
    SWEEP_CMP,
    PASS,
    FAIL
  } state_t;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_RESET_PC = 3'd1;
  localparam logic [2:0] FC_TIMEOUT  = 3'd2;
  localparam logic [2:0] FC_HALT_PC  = 3'd3;
  localparam logic [2:0] FC_DATA     = 3'd4;

endpackage

// File: rtl/check_sweeper.sv
// Walks the enabled expected-value channels in ascending order, supplying the
// snoop address and the compare result for the current channel.
module check_sweeper
#(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 16,
  parameter int N_CHECKS = 4,
  parameter int IDX_W    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic                       advance,
  input  logic [N_CHECKS-1:0]        exp_en,
  input  logic [N_CHECKS*ADDR_W-1:0] exp_addr,
  input  logic [N_CHECKS*DATA_W-1:0] exp_data,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [IDX_W-1:0]           idx,
  output logic                       any_en,
  output logic                       more,
  output logic                       mismatch,
  output logic [ADDR_W-1:0]          rd_addr
);

  logic [IDX_W-1:0] first_idx;
  logic [IDX_W-1:0] next_idx;

  // Disabled channels are skipped combinationally so they cost no cycles.
  always_comb begin
    any_en    = 1'b0;
    more      = 1'b0;
    first_idx = '0;
    next_idx  = '0;
    for (int unsigned i = 0; i < N_CHECKS; i++) begin
      if (exp_en[i] && !any_en) begin
        any_en    = 1'b1;
        first_idx = IDX_W'(i);
      end
      if (exp_en[i] && !more && (IDX_W'(i) > idx)) begin
        more     = 1'b1;
        next_idx = IDX_W'(i);
      end
    end
  end

  assign rd_addr  = exp_addr[idx*ADDR_W +: ADDR_W];
  assign mismatch = (mem_rdata != exp_data[idx*DATA_W +: DATA_W]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (load) begin
      idx <= first_idx;
    end else if (advance) begin
      idx <= next_idx;
    end
  end

endmodule

// File: rtl/run_checker.sv
// Run monitor: checks CPU reset PC, HALT within a cycle budget, the halt PC,
// then sweeps expected memory words through a snoop port and reports a verdict.
module run_checker
  import run_checker_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 16,
  parameter int N_CHECKS = 4,
  parameter int TIMEOUT  = 200,
  parameter int RESET_PC = 0,
  localparam int IDX_W   = (N_CHECKS > 1) ? $clog2(N_CHECKS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          cpu_pc,
  input  logic                       cpu_halt,
  input  logic [ADDR_W-1:0]          exp_halt_pc,
  input  logic [N_CHECKS-1:0]        exp_en,
  input  logic [N_CHECKS*ADDR_W-1:0] exp_addr,
  input  logic [N_CHECKS*DATA_W-1:0] exp_data,
  output logic                       mem_rd,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [2:0]                 fail_code,
  output logic [IDX_W-1:0]           fail_idx,
  output logic [15:0]                cycle_count
);

  localparam logic [15:0]       TIMEOUT_CNT = 16'(TIMEOUT);
  localparam logic [ADDR_W-1:0] RESET_PC_V  = ADDR_W'(RESET_PC);

  state_t            state;
  state_t            state_next;
  logic              halt_prev;
  logic              halt_edge;
  logic [15:0]       count_inc;
  logic              start_ok;
  logic              sweep_load;
  logic              sweep_advance;
  logic [IDX_W-1:0]  idx;
  logic              any_en;
  logic              more;
  logic              mismatch;
  logic [ADDR_W-1:0] rd_addr;

  check_sweeper #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .N_CHECKS (N_CHECKS),
    .IDX_W    (IDX_W)
  ) u_sweeper (
    .clk       (clk),
    .reset     (reset),
    .load      (sweep_load),
    .advance   (sweep_advance),
    .exp_en    (exp_en),
    .exp_addr  (exp_addr),
    .exp_data  (exp_data),
    .mem_rdata (mem_rdata),
    .idx       (idx),
    .any_en    (any_en),
    .more      (more),
    .mismatch  (mismatch),
    .rd_addr   (rd_addr)
  );

  assign halt_edge = cpu_halt & ~halt_prev;
  assign count_inc = (cycle_count == '1) ? cycle_count : cycle_count + 16'd1;
  assign start_ok  = start && ((state == IDLE) || (state == PASS) || (state == FAIL));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Timeout compares the post-increment count, so an edge seen on the cycle
  // the budget is reached still wins.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (start) state_next = RSTCHK;
      RSTCHK:    state_next = (cpu_pc != RESET_PC_V) ? FAIL : RUN;
      RUN: begin
        if (halt_edge) begin
          state_next = HALTCHK;
        end else if (count_inc == TIMEOUT_CNT) begin
          state_next = FAIL;
        end
      end
      HALTCHK: begin
        if (cpu_pc != exp_halt_pc) begin
          state_next = FAIL;
        end else begin
          state_next = any_en ? SWEEP_RD : PASS;
        end
      end
      SWEEP_RD:  state_next = SWEEP_CMP;
      SWEEP_CMP: begin
        if (mismatch) begin
          state_next = FAIL;
        end else begin
          state_next = more ? SWEEP_RD : PASS;
        end
      end
      PASS, FAIL: if (start) state_next = RSTCHK;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    pass          = 1'b0;
    mem_rd        = 1'b0;
    mem_addr      = '0;
    sweep_load    = 1'b0;
    sweep_advance = 1'b0;
    unique case (state)
      RSTCHK, RUN: busy = 1'b1;
      HALTCHK: begin
        busy       = 1'b1;
        sweep_load = 1'b1;
      end
      SWEEP_RD: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = rd_addr;
      end
      SWEEP_CMP: begin
        busy          = 1'b1;
        sweep_advance = !mismatch && more;
      end
      PASS: begin
        done = 1'b1;
        pass = 1'b1;
      end
      FAIL:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt_prev   <= 1'b0;
      cycle_count <= '0;
      fail_code   <= FC_NONE;
      fail_idx    <= '0;
    end else begin
      halt_prev <= cpu_halt;
      if (start_ok) begin
        cycle_count <= '0;
        fail_code   <= FC_NONE;
        fail_idx    <= '0;
      end else begin
        if (state == RUN) begin
          cycle_count <= count_inc;
        end
        if ((state_next == FAIL) && (state != FAIL)) begin
          case (state)
            RSTCHK:    fail_code <= FC_RESET_PC;
            RUN:       fail_code <= FC_TIMEOUT;
            HALTCHK:   fail_code <= FC_HALT_PC;
            SWEEP_CMP: begin
              fail_code <= FC_DATA;
              fail_idx  <= idx;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_run_checker.sv
// Bench for run_checker: table of hand-derived scenarios, abort/hold sequences,
// and randomized scenarios scored by a cycle-level outcome model.
module tb_run_checker;

  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 16;
  localparam int N_CHECKS = 4;
  localparam int TIMEOUT  = 200;
  localparam int RESET_PC = 0;
  localparam int LIMIT    = 400;

  typedef struct packed {
    logic [8:0]       rst_pc;
    int               pre_len;
    int               rise;
    logic [8:0]       halt_pc;
    logic [8:0]       exp_pc;
    logic [3:0]       en;
    logic [3:0][8:0]  addr;
    logic [3:0][15:0] data;
    int               restart_k;
  } scen_t;

  typedef struct packed {
    int         done_k;
    logic [2:0] code;
    logic [1:0] idx;
    logic       pass;
    logic [15:0] count;
    int         reads;
  } res_t;

  typedef struct packed {
    scen_t s;
    res_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  cpu_pc;
  logic        cpu_halt;
  logic [8:0]  exp_halt_pc;
  logic [3:0]  exp_en;
  logic [35:0] exp_addr;
  logic [63:0] exp_data;
  logic        mem_rd;
  logic [8:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic [2:0]  fail_code;
  logic [1:0]  fail_idx;
  logic [15:0] cycle_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  run_checker #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .N_CHECKS (N_CHECKS),
    .TIMEOUT  (TIMEOUT),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cpu_pc      (cpu_pc),
    .cpu_halt    (cpu_halt),
    .exp_halt_pc (exp_halt_pc),
    .exp_en      (exp_en),
    .exp_addr    (exp_addr),
    .exp_data    (exp_data),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_code   (fail_code),
    .fail_idx    (fail_idx),
    .cycle_count (cycle_count)
  );

  // Memory contents as left by the program: 0x10 holds 50, 0x14 holds 850.
  function automatic logic [15:0] memf(input logic [8:0] a);
    if (a == 9'h14) return 16'd850;
    if (a == 9'h10) return 16'd50;
    return 16'(a * 37 + 5);
  endfunction

  always_ff @(posedge clk) begin
    if (mem_rd) mem_rdata <= memf(mem_addr);
  end

  // CPU stimulus as a function of cycles since start (k=0 is the check cycle).
  function automatic logic halt_at(input scen_t s, input int k);
    return (k < s.pre_len) || (k >= s.rise);
  endfunction

  function automatic logic [8:0] pc_at(input scen_t s, input int k);
    if (k == 0) return s.rst_pc;
    if (k < s.rise) return 9'(k);
    return s.halt_pc;
  endfunction

  function automatic res_t predict(input scen_t s);
    res_t r;
    int ke;
    int n;
    r  = '0;
    ke = -1;
    n  = 0;
    if (s.rst_pc != 9'(RESET_PC)) begin
      r.done_k = 1;
      r.code   = 3'd1;
      return r;
    end
    for (int k = 1; k <= TIMEOUT; k++) begin
      if (ke < 0 && halt_at(s, k) && !halt_at(s, k - 1)) ke = k;
    end
    if (ke < 0) begin
      r.done_k = TIMEOUT + 1;
      r.code   = 3'd2;
      r.count  = 16'(TIMEOUT);
      return r;
    end
    r.count = 16'(ke);
    if (s.halt_pc != s.exp_pc) begin
      r.done_k = ke + 2;
      r.code   = 3'd3;
      return r;
    end
    for (int i = 0; i < N_CHECKS; i++) begin
      if (s.en[i]) begin
        n++;
        r.reads = n;
        if (memf(s.addr[i]) != s.data[i]) begin
          r.done_k = ke + 2 + 2 * n;
          r.code   = 3'd4;
          r.idx    = 2'(i);
          return r;
        end
      end
    end
    r.done_k = ke + 2 + 2 * n;
    r.pass   = 1'b1;
    return r;
  endfunction

  function automatic vec_t mk(input logic [8:0] rst_pc, input int pre, input int rise,
                              input logic [8:0] hpc, input logic [3:0] en,
                              input logic [35:0] addr, input logic [63:0] data,
                              input int dk, input logic [2:0] code, input logic [1:0] idx,
                              input logic ps, input logic [15:0] cnt, input int rd);
    vec_t v;
    v             = '0;
    v.s.rst_pc    = rst_pc;
    v.s.pre_len   = pre;
    v.s.rise      = rise;
    v.s.halt_pc   = hpc;
    v.s.exp_pc    = 9'h0F;
    v.s.en        = en;
    v.s.addr      = addr;
    v.s.data      = data;
    v.s.restart_k = -1;
    v.e.done_k    = dk;
    v.e.code      = code;
    v.e.idx       = idx;
    v.e.pass      = ps;
    v.e.count     = cnt;
    v.e.reads     = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // Entered on a negedge; returns on the negedge where done was first seen.
  task automatic run(input scen_t s, output res_t r, output logic clean_ok);
    r           = '0;
    r.done_k    = -1;
    clean_ok    = 1'b1;
    exp_halt_pc = s.exp_pc;
    exp_en      = s.en;
    exp_addr    = s.addr;
    exp_data    = s.data;
    start       = 1'b1;
    @(posedge clk);
    for (int k = 0; k < LIMIT; k++) begin
      @(negedge clk);
      start    = (k == s.restart_k);
      cpu_pc   = pc_at(s, k);
      cpu_halt = halt_at(s, k);
      if (mem_rd) r.reads++;
      if (k == 0 && (done || !busy || fail_code != 3'd0 || cycle_count != 16'd0)) clean_ok = 1'b0;
      if (done) begin
        r.done_k = k;
        r.code   = fail_code;
        r.idx    = fail_idx;
        r.pass   = pass;
        r.count  = cycle_count;
        break;
      end
      if (!busy) clean_ok = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic check_res(input string p, input res_t r, input res_t e, input logic ok);
    check({p, ".done_cycle"}, r.done_k, e.done_k);
    check({p, ".fail_code"}, r.code, e.code);
    check({p, ".fail_idx"}, r.idx, e.idx);
    check({p, ".pass"}, r.pass, e.pass);
    check({p, ".cycle_count"}, r.count, e.count);
    check({p, ".reads"}, r.reads, e.reads);
    check({p, ".busy_window"}, ok, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs[15];
    res_t  r;
    res_t  e;
    scen_t s;
    logic  ok;
    logic  seen;
    int    rk;

    vecs[0]  = mk(9'h0, 0, 16, 9'hF, 4'b0001, {9'h0, 9'h0, 9'h0, 9'h14},
                  {16'd0, 16'd0, 16'd0, 16'd850}, 20, 3'd0, 2'd0, 1'b1, 16'd16, 1);
    vecs[1]  = mk(9'h0, 0, 16, 9'hF, 4'b1101, {9'h20, 9'h10, 9'h0, 9'h14},
                  {16'd0, 16'd51, 16'd0, 16'd850}, 22, 3'd4, 2'd2, 1'b0, 16'd16, 2);
    vecs[2]  = mk(9'h0, 0, 1000, 9'hF, 4'b0000, '0, '0, 201, 3'd2, 2'd0, 1'b0, 16'd200, 0);
    vecs[3]  = mk(9'h5, 0, 16, 9'hF, 4'b0001, {9'h0, 9'h0, 9'h0, 9'h14},
                  {16'd0, 16'd0, 16'd0, 16'd850}, 1, 3'd1, 2'd0, 1'b0, 16'd0, 0);
    vecs[4]  = mk(9'h0, 0, 16, 9'hE, 4'b0001, {9'h0, 9'h0, 9'h0, 9'h14},
                  {16'd0, 16'd0, 16'd0, 16'd850}, 18, 3'd3, 2'd0, 1'b0, 16'd16, 0);
    vecs[5]  = mk(9'h0, 0, 200, 9'hF, 4'b0000, '0, '0, 202, 3'd0, 2'd0, 1'b1, 16'd200, 0);
    vecs[6]  = mk(9'h0, 0, 201, 9'hF, 4'b0000, '0, '0, 201, 3'd2, 2'd0, 1'b0, 16'd200, 0);
    vecs[7]  = mk(9'h0, 5, 5, 9'hF, 4'b0000, '0, '0, 201, 3'd2, 2'd0, 1'b0, 16'd200, 0);
    vecs[8]  = mk(9'h0, 3, 10, 9'hF, 4'b0000, '0, '0, 12, 3'd0, 2'd0, 1'b1, 16'd10, 0);
    vecs[9]  = mk(9'h0, 0, 16, 9'hF, 4'b1111, {9'h31, 9'h30, 9'h10, 9'h14},
                  {memf(9'h31), memf(9'h30), 16'd50, 16'd850}, 26, 3'd0, 2'd0, 1'b1, 16'd16, 4);
    vecs[10] = mk(9'h0, 0, 16, 9'hF, 4'b1010, {9'h14, 9'h0, 9'h10, 9'h0},
                  {16'd850, 16'd1, 16'd50, 16'd999}, 22, 3'd0, 2'd0, 1'b1, 16'd16, 2);
    vecs[11] = mk(9'h0, 0, 1, 9'hF, 4'b0000, '0, '0, 3, 3'd0, 2'd0, 1'b1, 16'd1, 0);
    vecs[12] = vecs[0];
    vecs[12].s.restart_k = 5;
    vecs[13] = mk(9'h0, 0, 16, 9'hF, 4'b0011, {9'h0, 9'h0, 9'h14, 9'h10},
                  {16'd0, 16'd0, 16'd850, 16'd51}, 20, 3'd4, 2'd0, 1'b0, 16'd16, 1);
    vecs[14] = mk(9'h0, 0, 16, 9'hF, 4'b1000, {9'h30, 9'h0, 9'h0, 9'h0},
                  {memf(9'h30) ^ 16'd1, 16'd0, 16'd0, 16'd0}, 20, 3'd4, 2'd3, 1'b0, 16'd16, 1);

    reset       = 1'b1;
    start       = 1'b0;
    cpu_pc      = '0;
    cpu_halt    = 1'b0;
    exp_halt_pc = '0;
    exp_en      = '0;
    exp_addr    = '0;
    exp_data    = '0;
    repeat (3) @(negedge clk);
    check("reset.outputs", {busy, done, pass, fail_code, fail_idx, cycle_count, mem_rd, mem_addr}, '0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      run(vecs[i].s, r, ok);
      check_res($sformatf("vec%0d", i), r, vecs[i].e, ok);
    end

    // Abort in the middle of the sweep, then a clean run.
    s           = vecs[9].s;
    exp_halt_pc = s.exp_pc;
    exp_en      = s.en;
    exp_addr    = s.addr;
    exp_data    = s.data;
    start       = 1'b1;
    @(posedge clk);
    seen = 1'b0;
    for (int k = 0; k < LIMIT && !seen; k++) begin
      @(negedge clk);
      start    = 1'b0;
      cpu_pc   = pc_at(s, k);
      cpu_halt = halt_at(s, k);
      if (mem_rd) seen = 1'b1;
    end
    check("abort.reached_sweep", seen, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("abort.outputs", {busy, done, pass, fail_code, fail_idx, cycle_count, mem_rd, mem_addr}, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run(vecs[0].s, r, ok);
    check_res("after_abort", r, vecs[0].e, ok);
    repeat (4) @(negedge clk);
    check("hold.done_pass", {done, pass, busy, fail_code}, 6'b110000);

    for (int n = 0; n < 40; n++) begin
      s         = '0;
      s.rst_pc  = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(1, 511)) : 9'(RESET_PC);
      s.pre_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      s.rise    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(190, 210))
                                              : int'($urandom_range(1, 40));
      s.exp_pc  = 9'($urandom_range(0, 511));
      s.halt_pc = ($urandom_range(0, 5) == 0) ? (s.exp_pc ^ 9'(1 << $urandom_range(0, 8))) : s.exp_pc;
      s.en      = 4'($urandom_range(0, 15));
      for (int i = 0; i < N_CHECKS; i++) begin
        s.addr[i] = 9'($urandom_range(0, 511));
        s.data[i] = memf(s.addr[i]) ^
                    (($urandom_range(0, 4) == 0) ? 16'($urandom_range(1, 65535)) : 16'd0);
      end
      e  = predict(s);
      rk = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 30)) : -1;
      if (rk >= e.done_k) rk = -1;
      s.restart_k = rk;
      run(s, r, ok);
      check_res($sformatf("rand%0d", n), r, e, ok);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
